// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types for the vending credit controller
package vend_pkg;

  localparam int UNIT_VALUE = 5;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD      = 2'd0,
    OP_ADD       = 2'd1,
    OP_SUB_PRICE = 2'd2,
    OP_DEC       = 2'd3
  } credit_op_t;

endpackage

// File: rtl/vend_credit_acc.sv
// rtl/vend_credit_acc.sv - credit register with add, subtract-price and decrement ops
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int PRICE    = 3,
  parameter int COIN_W   = 2,
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  credit_op_t          op,
  input  logic [COIN_W-1:0]   coin_units,
  output logic [CREDIT_W-1:0] credit,
  output logic                add_ok,
  output logic                price_met
);

  localparam logic [CREDIT_W:0]   MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W-1:0] PRICE_U    = CREDIT_W'(PRICE);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W:0]   sum;

  // Extra carry bit so an overflowing coin is detected instead of wrapping.
  always_comb begin
    sum       = {1'b0, credit_q} + (CREDIT_W+1)'(coin_units);
    add_ok    = (coin_units != '0) && (sum <= MAX_CREDIT);
    price_met = (credit_q >= PRICE_U);
  end

  always_comb begin
    credit_d = credit_q;
    case (op)
      OP_ADD:       credit_d = sum[CREDIT_W-1:0];
      OP_SUB_PRICE: credit_d = credit_q - PRICE_U;
      OP_DEC:       credit_d = credit_q - CREDIT_W'(1);
      default:      credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit = credit_q;

endmodule

// File: rtl/vend_credit_ctrl.sv
// rtl/vend_credit_ctrl.sv - vending FSM: collect coins, vend one item, pay change or refund
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE    = 3,
  parameter int COIN_W   = 2,
  parameter int CREDIT_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_units,
  input  logic                cancel,
  input  logic                change_ack,
  output logic                coin_reject,
  output logic                item,
  output logic                change_req,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [CNT_W-1:0]    sales
);

  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_VEND    = VEND;
  localparam logic [1:0] ST_CHANGE  = CHANGE;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] sales_q, sales_d;
  logic             coin_reject_q, coin_reject_d;
  logic             accept, add_ok, price_met;
  credit_op_t       op;

  vend_credit_acc #(
    .PRICE    (PRICE),
    .COIN_W   (COIN_W),
    .CREDIT_W (CREDIT_W)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .coin_units (coin_units),
    .credit     (credit),
    .add_ok     (add_ok),
    .price_met  (price_met)
  );

  // Vend beats cancel beats coin; a coin is only ever accepted in plain collect.
  always_comb begin
    state_d    = ST_COLLECT;
    sales_d    = sales_q;
    op         = OP_HOLD;
    accept     = 1'b0;
    item       = 1'b0;
    change_req = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        state_d = ST_COLLECT;
        if (price_met) begin
          state_d = ST_VEND;
          op      = OP_SUB_PRICE;
        end else if (cancel && (credit != '0)) begin
          state_d = ST_CHANGE;
        end else if (coin_valid && add_ok) begin
          op     = OP_ADD;
          accept = 1'b1;
        end
      end
      ST_VEND: begin
        item    = 1'b1;
        busy    = 1'b1;
        sales_d = sales_q + CNT_W'(1);
        state_d = (credit != '0) ? ST_CHANGE : ST_COLLECT;
      end
      ST_CHANGE: begin
        change_req = 1'b1;
        busy       = 1'b1;
        state_d    = ST_CHANGE;
        if (credit == '0) begin
          state_d = ST_COLLECT;
        end else if (change_ack) begin
          op = OP_DEC;
          if (credit == CREDIT_W'(1)) state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
    coin_reject_d = coin_valid && !accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_COLLECT;
      sales_q       <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sales_q       <= sales_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign coin_reject = coin_reject_q;
  assign sales       = sales_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb/tb_vend_credit_ctrl.sv - two-instance bench (PRICE 3 / PRICE 15) against a behavioural model
module tb_vend_credit_ctrl;

  localparam int M_COLLECT = 0;
  localparam int M_VEND    = 1;
  localparam int M_REFUND  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cv = '0;
  logic [1:0] cancel_i = '0;
  logic [1:0] ack_i = '0;
  logic [1:0] units [2];

  logic       a_rej, a_item, a_req, a_busy;
  logic [3:0] a_credit;
  logic [7:0] a_sales;
  logic       b_rej, b_item, b_req, b_busy;
  logic [3:0] b_credit;
  logic [1:0] b_sales;

  typedef struct {
    int phase;
    int credit;
    int sales;
    int rej;
  } mdl_t;

  mdl_t m [2];
  int checks = 0;
  int errors = 0;

  vend_credit_ctrl #(.PRICE(3), .COIN_W(2), .CREDIT_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .coin_valid(cv[0]), .coin_units(units[0]),
    .cancel(cancel_i[0]), .change_ack(ack_i[0]), .coin_reject(a_rej), .item(a_item),
    .change_req(a_req), .credit(a_credit), .busy(a_busy), .sales(a_sales)
  );

  vend_credit_ctrl #(.PRICE(15), .COIN_W(2), .CREDIT_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .coin_valid(cv[1]), .coin_units(units[1]),
    .cancel(cancel_i[1]), .change_ack(ack_i[1]), .coin_reject(b_rej), .item(b_item),
    .change_req(b_req), .credit(b_credit), .busy(b_busy), .sales(b_sales)
  );

  initial forever #5 clk = ~clk;

  function automatic mdl_t step(mdl_t s, int price, int cnt_w, bit c, int u, bit cn, bit ak);
    mdl_t n = s;
    n.rej = 0;
    if (s.phase == M_COLLECT) begin
      if (s.credit >= price) begin
        n.credit = s.credit - price;
        n.phase  = M_VEND;
        n.rej    = int'(c);
      end else if (cn && s.credit > 0) begin
        n.phase = M_REFUND;
        n.rej   = int'(c);
      end else if (c) begin
        if (u == 0 || s.credit + u > 15) n.rej = 1;
        else n.credit = s.credit + u;
      end
    end else if (s.phase == M_VEND) begin
      n.rej   = int'(c);
      n.sales = (s.sales + 1) % (1 << cnt_w);
      n.phase = (s.credit > 0) ? M_REFUND : M_COLLECT;
    end else begin
      n.rej = int'(c);
      if (ak) begin
        n.credit = s.credit - 1;
        if (n.credit == 0) n.phase = M_COLLECT;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_credit", int'(a_credit), m[0].credit);
    chk("a_item", int'(a_item), int'(m[0].phase == M_VEND));
    chk("a_change_req", int'(a_req), int'(m[0].phase == M_REFUND));
    chk("a_busy", int'(a_busy), int'(m[0].phase != M_COLLECT));
    chk("a_sales", int'(a_sales), m[0].sales);
    chk("a_coin_reject", int'(a_rej), m[0].rej);
    chk("b_credit", int'(b_credit), m[1].credit);
    chk("b_item", int'(b_item), int'(m[1].phase == M_VEND));
    chk("b_change_req", int'(b_req), int'(m[1].phase == M_REFUND));
    chk("b_busy", int'(b_busy), int'(m[1].phase != M_COLLECT));
    chk("b_sales", int'(b_sales), m[1].sales);
    chk("b_coin_reject", int'(b_rej), m[1].rej);
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m[i] = '{M_COLLECT, 0, 0, 0};
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m[0] = step(m[0], 3, 8, cv[0], int'(units[0]), cancel_i[0], ack_i[0]);
      m[1] = step(m[1], 15, 2, cv[1], int'(units[1]), cancel_i[1], ack_i[1]);
    end
    #1;
  endtask

  task automatic drv(input int k, input bit c, input int u, input bit cn, input bit ak);
    cv = '0;
    cancel_i = '0;
    ack_i = '0;
    units[0] = 2'd0;
    units[1] = 2'd0;
    cv[k] = c;
    units[k] = 2'(u);
    cancel_i[k] = cn;
    ack_i[k] = ak;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    cv = '0;
    cancel_i = '0;
    ack_i = '0;
    reset = 1'b1;
    model_reset();
    #1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    units[0] = 2'd0;
    units[1] = 2'd0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_a_credit", int'(a_credit), 0);
    chk("rst_a_sales", int'(a_sales), 0);
    chk("rst_b_busy", int'(b_busy), 0);

    // exact payment on A
    drv(0, 1, 1, 0, 0);  chk("exact_credit1", int'(a_credit), 1);
    drv(0, 1, 2, 0, 0);  chk("exact_credit3", int'(a_credit), 3);
    idle(1);             chk("exact_item", int'(a_item), 1);
                         chk("exact_credit0", int'(a_credit), 0);
                         chk("model_exact_vend", int'(m[0].phase == M_VEND), 1);
    idle(1);             chk("exact_no_req", int'(a_req), 0);
                         chk("exact_sales", int'(a_sales), 1);

    // overpay with change
    drv(0, 1, 2, 0, 0);
    drv(0, 1, 2, 0, 0);  chk("over_credit4", int'(a_credit), 4);
    idle(1);             chk("over_item", int'(a_item), 1);
                         chk("over_credit1", int'(a_credit), 1);
    idle(1);             chk("over_req", int'(a_req), 1);
    idle(3);             chk("over_stall_credit", int'(a_credit), 1);
                         chk("over_stall_req", int'(a_req), 1);
    drv(0, 0, 0, 0, 1);  chk("over_ack_credit", int'(a_credit), 0);
                         chk("over_ack_req", int'(a_req), 0);
                         chk("model_over_sales", m[0].sales, 2);

    // cancel refund
    drv(0, 1, 2, 0, 0);
    drv(0, 0, 0, 1, 0);  chk("cancel_req", int'(a_req), 1);
                         chk("cancel_credit", int'(a_credit), 2);
                         chk("cancel_item", int'(a_item), 0);
    drv(0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 1);  chk("cancel_done", int'(a_credit), 0);
                         chk("cancel_sales", int'(a_sales), 2);

    // overflow and zero coin on B
    repeat (4) drv(1, 1, 3, 0, 0);
    drv(1, 1, 2, 0, 0);  chk("ovf_credit14", int'(b_credit), 14);
    drv(1, 1, 3, 0, 0);  chk("ovf_reject", int'(b_rej), 1);
                         chk("ovf_credit_held", int'(b_credit), 14);
    drv(1, 1, 0, 0, 0);  chk("zero_reject", int'(b_rej), 1);
    drv(1, 1, 1, 0, 0);  chk("fill_credit15", int'(b_credit), 15);
                         chk("fill_no_reject", int'(b_rej), 0);
    idle(1);             chk("b_vend_item", int'(b_item), 1);
    idle(1);             chk("b_sales1", int'(b_sales), 1);

    // coins while busy, cancel versus vend
    drv(0, 1, 2, 0, 0);
    drv(0, 1, 2, 0, 0);
    drv(0, 1, 1, 0, 0);  chk("price_met_reject", int'(a_rej), 1);
    drv(0, 1, 1, 0, 0);  chk("vend_coin_reject", int'(a_rej), 1);
    drv(0, 1, 1, 0, 0);  chk("change_coin_reject", int'(a_rej), 1);
                         chk("change_coin_credit", int'(a_credit), 1);
    drv(0, 0, 0, 0, 1);
    drv(0, 1, 2, 0, 0);
    drv(0, 1, 1, 0, 0);
    drv(0, 0, 0, 1, 0);  chk("cancel_vs_vend_item", int'(a_item), 1);
                         chk("cancel_vs_vend_req", int'(a_req), 0);
    idle(1);             chk("cancel_vs_vend_sales", int'(a_sales), 4);

    // reset mid-change on B
    drv(1, 1, 3, 0, 0);
    drv(1, 0, 0, 1, 0);  chk("pre_rst_req", int'(b_req), 1);
                         chk("pre_rst_credit", int'(b_credit), 3);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_credit", int'(b_credit), 0);
    chk("rst_mid_req", int'(b_req), 0);
    chk("rst_mid_item", int'(b_item), 0);
    tick();
    reset = 1'b0;
    drv(1, 1, 2, 0, 0);  chk("post_rst_coin", int'(b_credit), 2);

    // sales wrap at CNT_W=2
    drv(1, 1, 1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      repeat ((r == 0) ? 4 : 5) drv(1, 1, 3, 0, 0);
      idle(1);
      chk("wrap_item", int'(b_item), 1);
      idle(1);
      if (r == 2) chk("wrap_sales3", int'(b_sales), 3);
    end
    chk("wrap_sales0", int'(b_sales), 0);

    // randomized traffic on both instances
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 700 == 0) begin
        pulse_reset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          cv[k] = ($urandom % 3 == 0);
          units[k] = 2'($urandom % 4);
          cancel_i[k] = ($urandom % 12 == 0);
          ack_i[k] = ($urandom % 3 != 0);
        end
        tick();
      end
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
- Parametrised successor to the fixed-price 5/10 vending FSM.
- Accumulates multi-denomination coin credit in base units (1 unit = 5) against a parametrised PRICE, then dispenses one item.
- Returns change or a cancel refund one unit at a time over a req/ack handshake to a coin dispenser.
- Sits between the coin acceptor front end and the item and change actuators.

Parameters:
- PRICE, 3, item price in base units; legal range 1..MAX_CREDIT.
- COIN_W, 2, width of the coin value input in base units (coin values 1..2**COIN_W-1).
- CREDIT_W, 4, credit register width; MAX_CREDIT = 2**CREDIT_W-1.
- CNT_W, 8, width of the wrapping sales counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- coin_valid  in  1  one-cycle strobe: coin presented this cycle
- coin_units  in  COIN_W  coin value in base units, sampled when coin_valid=1
- cancel  in  1  level/pulse: request refund of held credit
- change_ack  in  1  dispenser accepted one unit of change this cycle
- coin_reject  out  1  registered one-cycle pulse: previous-cycle coin was not accepted
- item  out  1  one-cycle vend pulse (Moore, high in VEND)
- change_req  out  1  high while in CHANGE
- credit  out  CREDIT_W  current credit in base units
- busy  out  1  high in VEND or CHANGE
- sales  out  CNT_W  count of vends, wraps modulo 2**CNT_W

Behaviour:
- Reset (async, any state): state=COLLECT; credit=0, sales=0, coin_reject=0. Outputs item=0, change_req=0, busy=0.
- States: COLLECT, VEND, CHANGE.
- COLLECT:
  - Priority 1, credit>=PRICE: next=VEND, credit<=credit-PRICE. A coin this cycle is rejected. cancel is ignored (vend wins).
  - Priority 2, cancel=1 and credit>0: next=CHANGE, credit unchanged (full refund). A coin this cycle is rejected.
  - Priority 3, coin_valid=1:
    - if coin_units==0 or credit+coin_units>MAX_CREDIT (compute at CREDIT_W+1 bits), reject;
    - else credit<=credit+coin_units.
  - cancel with credit==0: ignored.
- VEND: lasts exactly 1 cycle; item=1; sales<=sales+1. Next=CHANGE if credit>0, else COLLECT. Any coin is rejected.
- CHANGE:
  - change_req=1.
  - Each cycle with change_ack=1: credit<=credit-1.
  - If change_ack=1 and credit==1: next=COLLECT.
  - change_ack while not in CHANGE is ignored. Any coin is rejected.
  - Stalls indefinitely without ack; no timeout.
- coin_reject: registered. Asserted in cycle N+1 for a coin_valid in cycle N that was not accepted; otherwise 0.
- Latency:
  - coin accepted to credit visible: 1 cycle;
  - credit reaching PRICE to item: 1 cycle;
  - item to first change_req: 1 cycle.
- Overpayment example (PRICE=3, credit=4): VEND leaves credit=1, then CHANGE returns 1 unit.
- Reset mid-CHANGE: remaining credit is discarded and returns to 0; no further change_req.
- No X on outputs after reset. Illegal state encoding: next=COLLECT, outputs 0.

Decomposition:
- Package vend_pkg: state_t enum (COLLECT=2'd0, VEND=2'd1, CHANGE=2'd2) and a UNIT_VALUE=5 constant for documentation and bench scoreboards.
- One natural sub-module, vend_credit_acc: credit register with add/saturation-check/subtract-PRICE/decrement ops, selected by FSM controls.
- FSM and sales counter stay in the top module.

Test Plan:
- Exact payment: PRICE=3; coins 1,2 on consecutive cycles → credit 1 then 3, item pulse 1 cycle later, credit=0, back to COLLECT, no change_req, sales=1.
- Overpay with change: coins 2,2 → credit=4; item; credit=1; change_req=1. Hold change_ack=0 for 3 cycles: credit stays 1. Ack once → credit=0, COLLECT.
- Cancel refund: coin 2 then cancel → CHANGE with credit=2, no item. Two acks → credit=0, sales unchanged.
- Overflow and zero coin: with CREDIT_W=4 and PRICE=15, credit=14, coin 3 → coin_reject next cycle, credit stays 14. A coin_units=0 strobe is also rejected.
- Busy/simultaneity: coin during VEND and during CHANGE → each rejected. cancel and credit>=PRICE in the same cycle → vend taken.
- Reset mid-CHANGE with credit=3 → immediately credit=0, change_req=0, item=0. Next coin is accepted normally. Sales wrap checked at CNT_W=2 after 4 vends → sales=0.
